// File: rtl/alu_pkg.sv
// ----------------------------------------------------------------------------
// alu_pkg
//  Shared definitions for the alu_mdu execute unit: op-code values carried on
//  the 5-bit control bus, the control FSM state encoding, and a helper that
//  classifies an op code as belonging to the multi-cycle mul/div group.
// ----------------------------------------------------------------------------
package alu_pkg;

    // Single-cycle base ops
    localparam logic [4:0] OP_ADD    = 5'd0;
    localparam logic [4:0] OP_SUB    = 5'd1;
    localparam logic [4:0] OP_SLL    = 5'd2;
    localparam logic [4:0] OP_SLT    = 5'd3;
    localparam logic [4:0] OP_SLTU   = 5'd4;
    localparam logic [4:0] OP_XOR    = 5'd5;
    localparam logic [4:0] OP_SRL    = 5'd6;
    localparam logic [4:0] OP_SRA    = 5'd7;
    localparam logic [4:0] OP_OR     = 5'd8;
    localparam logic [4:0] OP_AND    = 5'd9;
    localparam logic [4:0] OP_LUI    = 5'd10;

    // Multi-cycle mul/div ops; the low three bits are the mdu_serial sub-op
    localparam logic [4:0] OP_MUL    = 5'd16;
    localparam logic [4:0] OP_MULH   = 5'd17;
    localparam logic [4:0] OP_MULHSU = 5'd18;
    localparam logic [4:0] OP_MULHU  = 5'd19;
    localparam logic [4:0] OP_DIV    = 5'd20;
    localparam logic [4:0] OP_DIVU   = 5'd21;
    localparam logic [4:0] OP_REM    = 5'd22;
    localparam logic [4:0] OP_REMU   = 5'd23;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Codes 16..23 form the mul/div group
    function automatic logic is_mdu_op(input logic [4:0] control);
        return control[4:3] == 2'b10;
    endfunction

endpackage

// File: rtl/mdu_serial.sv
// ----------------------------------------------------------------------------
// mdu_serial
//  Bit-serial multiply / restoring divide on operand magnitudes.
//  start loads the operands; W iteration cycles follow, then one fix cycle in
//  which 'done' is high and 'result' carries the sign-corrected, word-selected
//  value (combinational from the internal registers).
// Ports:
//  clk, rstn      clock, async active-low reset
//  start          load a/b/op and begin iterating
//  abort          synchronous cancel of any run in progress
//  op[2:0]        0 MUL 1 MULH 2 MULHSU 3 MULHU 4 DIV 5 DIVU 6 REM 7 REMU
//  a, b           operands (a = multiplicand/dividend, b = multiplier/divisor)
//  last           high during the final iteration cycle
//  done           high during the fix cycle; result valid
//  result         final W-bit result
// ----------------------------------------------------------------------------
module mdu_serial
    import alu_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         start,
    input  logic         abort,
    input  logic [2:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         last,
    output logic         done,
    output logic [W-1:0] result
);

    localparam int CW = $clog2(W);

    logic         running;
    logic         fix;
    logic         is_div;
    logic         sel_hi;     // mul: return high word; div: return remainder
    logic         neg;        // negate the selected result in the fix cycle
    logic [CW-1:0] cnt;
    logic [W-1:0] hi;         // mul: accumulator high word; div: partial remainder
    logic [W-1:0] lo;         // mul: shifting multiplier/product low; div: quotient
    logic [W-1:0] m;          // mul: multiplicand magnitude; div: divisor magnitude

    // Operand decode at start
    logic         signed_a, signed_b, sa, sb;
    logic [W-1:0] mag_a, mag_b;

    // NOTE: every signal driven in always_comb gets a default first, so no
    // path through the block leaves it unassigned and infers a latch.
    always_comb begin
        signed_a = 1'b0;
        signed_b = 1'b0;
        case (op)
            3'd0, 3'd1, 3'd4, 3'd6: begin signed_a = 1'b1; signed_b = 1'b1; end
            3'd2:                   begin signed_a = 1'b1; end
            default:                ;
        endcase
        sa    = signed_a & a[W-1];
        sb    = signed_b & b[W-1];
        mag_a = sa ? -a : a;
        mag_b = sb ? -b : b;
    end

    // Iteration datapath
    logic [W:0]   mul_sum;
    logic [W:0]   div_shift;
    logic [W:0]   div_diff;
    logic         div_ge;

    assign mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, m} : '0);
    assign div_shift = {hi, lo[W-1]};
    assign div_diff  = div_shift - {1'b0, m};
    assign div_ge    = div_shift >= {1'b0, m};

    assign last = running && (cnt == CW'(W - 1));
    assign done = fix;

    // Fix: sign correction and word select
    logic [2*W-1:0] prod, prod_fix;
    logic [W-1:0]   div_sel;

    assign prod     = {hi, lo};
    assign prod_fix = neg ? -prod : prod;
    assign div_sel  = sel_hi ? hi : lo;
    assign result   = is_div ? (neg ? -div_sel : div_sel)
                             : (sel_hi ? prod_fix[2*W-1:W] : prod_fix[W-1:0]);

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            running <= 1'b0;
            fix     <= 1'b0;
            cnt     <= '0;
            is_div  <= 1'b0;
            sel_hi  <= 1'b0;
            neg     <= 1'b0;
            hi      <= '0;
            lo      <= '0;
            m       <= '0;
        end else if (abort) begin
            running <= 1'b0;
            fix     <= 1'b0;
            cnt     <= '0;
        end else if (start) begin
            running <= 1'b1;
            fix     <= 1'b0;
            cnt     <= '0;
            is_div  <= op[2];
            hi      <= '0;
            if (op[2]) begin
                lo     <= mag_a;
                m      <= mag_b;
                sel_hi <= op[1];
                // Remainder takes the dividend's sign, quotient the xor
                neg    <= op[1] ? sa : (sa ^ sb);
            end else begin
                lo     <= mag_b;
                m      <= mag_a;
                sel_hi <= (op[1:0] != 2'd0);
                neg    <= sa ^ sb;
            end
        end else if (running) begin
            if (is_div) begin
                hi <= div_ge ? div_diff[W-1:0] : div_shift[W-1:0];
                lo <= {lo[W-2:0], div_ge};
            end else begin
                hi <= mul_sum[W:1];
                lo <= {mul_sum[0], lo[W-1:1]};
            end
            if (last) begin
                running <= 1'b0;
                fix     <= 1'b1;
                cnt     <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end else if (fix) begin
            fix <= 1'b0;
        end
    end

endmodule

// File: rtl/alu_mdu.sv
// ----------------------------------------------------------------------------
// alu_mdu
//  RV32I ALU plus RV32M mul/div/rem execute unit with valid/ready handshakes.
//  Base ops, unknown codes and divide special cases complete at the accepting
//  edge; mul/div ops go through mdu_serial (W iterations + fix cycle).
// Ports:
//  clk, rstn          clock, async active-low reset
//  flush              synchronous abort of any in-flight or held op
//  in_valid/in_ready  operand handshake (in_ready high only in IDLE)
//  srca, srcb         operands
//  control            op code (alu_pkg)
//  out_valid/out_ready result handshake; result held until taken
//  y                  result
//  zero               registered y == 0
// ----------------------------------------------------------------------------
module alu_mdu
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] srca,
    input  logic [DATA_WIDTH-1:0] srcb,
    input  logic [4:0]            control,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] y,
    output logic                  zero
);

    localparam int SHAMT_W = $clog2(DATA_WIDTH);
    localparam logic [DATA_WIDTH-1:0] SMIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    state_t state;

    logic [SHAMT_W-1:0]    shamt;
    logic [DATA_WIDTH-1:0] alu_res;
    logic                  div_op, b_zero, ovf, special;
    logic [DATA_WIDTH-1:0] fast_res;
    logic                  accept, mdu_start;
    logic                  mdu_last, mdu_done;
    logic [DATA_WIDTH-1:0] mdu_result;

    assign shamt = srcb[SHAMT_W-1:0];

    always_comb begin
        alu_res = '0;
        case (control)
            OP_ADD:  alu_res = srca + srcb;
            OP_SUB:  alu_res = srca - srcb;
            OP_SLL:  alu_res = srca << shamt;
            OP_SLT:  alu_res = {{(DATA_WIDTH-1){1'b0}}, $signed(srca) < $signed(srcb)};
            OP_SLTU: alu_res = {{(DATA_WIDTH-1){1'b0}}, srca < srcb};
            OP_XOR:  alu_res = srca ^ srcb;
            OP_SRL:  alu_res = srca >> shamt;
            OP_SRA:  alu_res = $signed(srca) >>> shamt;
            OP_OR:   alu_res = srca | srcb;
            OP_AND:  alu_res = srca & srcb;
            OP_LUI:  alu_res = srcb << 12;
            default: alu_res = '0;
        endcase
    end

    // Divide special cases bypass the serial datapath. Overflow applies only
    // to the signed forms (DIV/REM have control[0] == 0).
    assign div_op  = is_mdu_op(control) && control[2];
    assign b_zero  = (srcb == '0);
    assign ovf     = !control[0] && (srca == SMIN) && (srcb == '1);
    assign special = div_op && (b_zero || ovf);

    always_comb begin
        fast_res = alu_res;
        if (special) begin
            if (b_zero) fast_res = control[1] ? srca : '1;
            else        fast_res = control[1] ? '0   : srca;
        end
    end

    // flush wins over acceptance in the same cycle
    assign accept    = in_valid && in_ready && !flush;
    assign mdu_start = accept && is_mdu_op(control) && !special;

    mdu_serial #(.W(DATA_WIDTH)) u_mdu (
        .clk    (clk),
        .rstn   (rstn),
        .start  (mdu_start),
        .abort  (flush),
        .op     (control[2:0]),
        .a      (srca),
        .b      (srcb),
        .last   (mdu_last),
        .done   (mdu_done),
        .result (mdu_result)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= ST_IDLE;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            y         <= '0;
            zero      <= 1'b1;
        end else if (flush) begin
            // y/zero keep their last values; the held result is discarded
            state     <= ST_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    in_ready <= 1'b1;
                    if (accept) begin
                        in_ready <= 1'b0;
                        if (mdu_start) begin
                            state <= ST_BUSY;
                        end else begin
                            y         <= fast_res;
                            zero      <= (fast_res == '0);
                            out_valid <= 1'b1;
                            state     <= ST_DONE;
                        end
                    end
                end
                ST_BUSY: begin
                    if (mdu_last) state <= ST_FIX;
                end
                ST_FIX: begin
                    if (mdu_done) begin
                        y         <= mdu_result;
                        zero      <= (mdu_result == '0);
                        out_valid <= 1'b1;
                        state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // Drain cycle never accepts; in_ready rises next cycle
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mdu.sv
// ----------------------------------------------------------------------------
// tb_alu_mdu
//  Directed, table-driven bench for alu_mdu (DATA_WIDTH = 32) plus hand-written
//  sequences for reset during a divide, backpressure and flush.
// ----------------------------------------------------------------------------
module tb_alu_mdu;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] srca = '0;
    logic [31:0] srcb = '0;
    logic [4:0]  control = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] y;
    logic        zero;

    int n_checks = 0;
    int n_fail   = 0;

    alu_mdu #(.DATA_WIDTH(32)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .srca      (srca),
        .srcb      (srcb),
        .control   (control),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  ctrl;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
        string       name;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] e, input int lat, input string name);
        vec_t v;
        v.ctrl = c; v.a = a; v.b = b; v.exp = e; v.lat = lat; v.name = name;
        vecs.push_back(v);
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("in_ready_wait", 32'(in_ready), 32'd1);
    endtask

    // Issue one op, measure edges to out_valid (accept edge counts as 1),
    // optionally hold the result under backpressure, then drain it.
    task automatic run_op(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] e, input int lat, input int hold, input string name);
        int n = 0;
        wait_ready();
        control = c; srca = a; srcb = b; in_valid = 1'b1;
        do begin
            @(posedge clk); #1;
            n++;
            if (n == 1) in_valid = 1'b0;
        end while (!out_valid && n < 100);
        check({name, "_lat"}, 32'(n), 32'(lat));
        check(name, y, e);
        check({name, "_zero"}, 32'(zero), 32'(e == 32'd0));
        for (int h = 0; h < hold; h++) begin
            // Operand churn while not ready must have no effect
            control = OP_ADD; srca = $urandom; srcb = $urandom; in_valid = 1'b1;
            @(posedge clk); #1;
            check({name, "_hold_valid"}, 32'(out_valid), 32'd1);
            check({name, "_hold_y"}, y, e);
            check({name, "_hold_zero"}, 32'(zero), 32'(e == 32'd0));
            check({name, "_hold_in_ready"}, 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({name, "_drained"}, 32'(out_valid), 32'd0);
        check({name, "_ready_after"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        int seen;

        // ---- reset state (async, before any release) ----
        #12;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_y", y, 32'd0);
        check("rst_zero", 32'(zero), 32'd1);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        rstn = 1'b1;

        // ---- vector table ----
        add_vec(OP_ADD,    32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000,  1, "add_ovf");
        add_vec(OP_SLL,    32'h0000_0001, 32'h0000_0024, 32'h0000_0010,  1, "sll");
        add_vec(OP_SLT,    32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001,  1, "slt");
        add_vec(OP_SLTU,   32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000,  1, "sltu");
        add_vec(OP_XOR,    32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0,  1, "xor");
        add_vec(OP_SRL,    32'h8000_0000, 32'h0000_001F, 32'h0000_0001,  1, "srl");
        add_vec(OP_SRA,    32'h8000_0000, 32'h0000_0021, 32'hC000_0000,  1, "sra");
        add_vec(OP_OR,     32'h1234_0000, 32'h0000_5678, 32'h1234_5678,  1, "or");
        add_vec(OP_AND,    32'hFFFF_0000, 32'h1234_5678, 32'h1234_0000,  1, "and");
        add_vec(OP_LUI,    32'hDEAD_BEEF, 32'h0001_2345, 32'h1234_5000,  1, "lui");
        add_vec(5'd11,     32'h0000_0005, 32'h0000_0005, 32'h0000_0000,  1, "unknown");
        add_vec(OP_MUL,    32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFA, 34, "mul");
        add_vec(OP_MULH,   32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 34, "mulh");
        add_vec(OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, "mulhsu");
        add_vec(OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34, "mulhu");
        add_vec(OP_MUL,    32'h0001_2345, 32'h0000_1000, 32'h1234_5000, 34, "mul_pos");
        add_vec(OP_DIV,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 34, "div_neg");
        add_vec(OP_REM,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 34, "rem_neg");
        add_vec(OP_REM,    32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 34, "rem_negdiv");
        add_vec(OP_DIVU,   32'h0000_0064, 32'h0000_0007, 32'h0000_000E, 34, "divu");
        add_vec(OP_REMU,   32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 34, "remu");
        add_vec(OP_DIVU,   32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF,  1, "divu_by0");
        add_vec(OP_REMU,   32'h0000_0005, 32'h0000_0000, 32'h0000_0005,  1, "remu_by0");
        add_vec(OP_DIV,    32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF,  1, "div_by0");
        add_vec(OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000,  1, "div_ovf");
        add_vec(OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000,  1, "rem_ovf");

        foreach (vecs[i])
            run_op(vecs[i].ctrl, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat, 0, vecs[i].name);

        // ---- backpressure: SUB(3,3) held 5 cycles ----
        run_op(OP_SUB, 32'd3, 32'd3, 32'd0, 1, 5, "sub_bp");

        // ---- reset mid-DIV (iteration 10) ----
        run_op(OP_ADD, 32'd40, 32'd2, 32'd42, 1, 0, "pre_rst_add");
        wait_ready();
        control = OP_DIV; srca = 32'hFFFF_FFF9; srcb = 32'd2; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("busy_in_ready", 32'(in_ready), 32'd0);
        rstn = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_y", y, 32'd0);
        check("midrst_zero", 32'(zero), 32'd1);
        check("midrst_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rstn = 1'b1;
        run_op(OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34, 0, "post_rst_rem");

        // ---- flush at BUSY iteration 7 with in_valid high ----
        run_op(OP_SLL, 32'd1, 32'd4, 32'h10, 1, 0, "pre_flush_sll");
        wait_ready();
        control = OP_DIVU; srca = 32'd100; srcb = 32'd7; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        flush = 1'b1; in_valid = 1'b1; control = OP_ADD; srca = 32'd1; srcb = 32'd1;
        @(posedge clk); #1;
        check("flush_idle_ready", 32'(in_ready), 32'd1);
        check("flush_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        check("flush_no_accept", 32'(in_ready), 32'd1);
        flush = 1'b0; in_valid = 1'b0;
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        check("flush_never_valid", 32'(seen), 32'd0);
        check("flush_y_kept", y, 32'h10);
        run_op(OP_ADD, 32'd1, 32'd1, 32'd2, 1, 0, "post_flush_add");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Absolute time limit so the run always terminates
    initial begin
        #200000;
        $display("FAIL timeout: got no completion expected completion");
        $fatal(1, "timeout");
    end

endmodule
